// File: rtl/gray_pkg.sv
// Shared definitions for the grayscale row serializer and its position counter.
//   DEF_COLS / DEF_ROWS / DEF_WIDTH : default geometry (pixels per row, rows per frame, bits per pixel)
//   DEF_COL_W / DEF_ROW_W           : counter widths for the default geometry
//   ser_state_e                     : serializer FSM state encoding
package gray_pkg;

  localparam int unsigned DEF_COLS  = 256;
  localparam int unsigned DEF_ROWS  = 256;
  localparam int unsigned DEF_WIDTH = 8;

  localparam int unsigned DEF_COL_W = $clog2(DEF_COLS);
  localparam int unsigned DEF_ROW_W = $clog2(DEF_ROWS);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_e;

endpackage : gray_pkg

// File: rtl/gray_row_serializer_pos_counter.sv
// Column/row position counter with explicit wrap and end/start markers.
//   clk, rst_n : clock, asynchronous active-low reset
//   adv        : advance one pixel position this cycle
//   col, row   : current column / row within the frame
//   eol        : col == COLS-1
//   sof        : row == 0 && col == 0
//   eof        : row == ROWS-1 && eol
module gray_pos_counter
  import gray_pkg::*;
#(
  parameter  int unsigned COLS  = DEF_COLS,
  parameter  int unsigned ROWS  = DEF_ROWS,
  localparam int unsigned COL_W = $clog2(COLS),
  localparam int unsigned ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             eol,
  output logic             sof,
  output logic             eof
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Wrap is compared explicitly so non-power-of-two geometries behave.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (adv) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  always_comb begin
    col = col_q;
    row = row_q;
    eol = (col_q == COL_LAST);
    sof = (row_q == '0) && (col_q == '0);
    eof = (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

endmodule : gray_pos_counter

// File: rtl/gray_row_serializer.sv
// Accepts one packed gray row and streams it one pixel per beat, column 0 first.
//   clk, rst_n            : clock, asynchronous active-low reset
//   row_valid / row_ready : row handshake; row_data captured when both high
//   row_data              : pixel c at [WIDTH*c +: WIDTH]
//   pix_valid / pix_ready : pixel handshake; a beat is both high
//   pix_data              : current pixel
//   pix_col / pix_row     : position of pix_data within the frame
//   pix_eol/sof/eof       : position decodes, not gated by pix_valid
//   busy                  : a row is being streamed
module gray_row_serializer
  import gray_pkg::*;
#(
  parameter  int unsigned COLS  = DEF_COLS,
  parameter  int unsigned ROWS  = DEF_ROWS,
  parameter  int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned COL_W = $clog2(COLS),
  localparam int unsigned ROW_W = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  row_valid,
  output logic                  row_ready,
  input  logic [COLS*WIDTH-1:0] row_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [WIDTH-1:0]      pix_data,
  output logic [COL_W-1:0]      pix_col,
  output logic [ROW_W-1:0]      pix_row,
  output logic                  pix_eol,
  output logic                  pix_sof,
  output logic                  pix_eof,
  output logic                  busy
);

  ser_state_e state_q, state_d;

  logic [COLS*WIDTH-1:0] buf_q, buf_d;

  logic             beat;
  logic             capture;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             eol;
  logic             sof;
  logic             eof;

  gray_pos_counter #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (beat),
    .col   (col),
    .row   (row),
    .eol   (eol),
    .sof   (sof),
    .eof   (eof)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        // Last beat with a row waiting reloads in the same cycle: no bubble.
        if (beat && eol) begin
          state_d = capture ? STREAM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and handshake decode
  always_comb begin
    pix_valid = (state_q == STREAM);
    busy      = (state_q == STREAM);
    beat      = pix_valid && pix_ready;
    // pix_ready feeds row_ready combinationally so the next row can be
    // taken on the last beat.
    row_ready = (state_q == IDLE) || ((state_q == STREAM) && pix_ready && eol);
    capture   = row_valid && row_ready;
    pix_data  = '0;
    if (state_q == STREAM) begin
      pix_data = buf_q[int'(col)*WIDTH +: WIDTH];
    end
    pix_col = col;
    pix_row = row;
    pix_eol = eol;
    pix_sof = sof;
    pix_eof = eof;
  end

  // Row buffer: row_data is only sampled on capture.
  always_comb begin
    buf_d = buf_q;
    if (capture) begin
      buf_d = row_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

endmodule : gray_row_serializer

// File: tb/tb_gray_row_serializer.sv
module tb_gray_row_serializer;

  localparam int unsigned C  = 256;
  localparam int unsigned R  = 256;
  localparam int unsigned W  = 8;
  localparam int unsigned SC = 8;
  localparam int unsigned SR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Default-geometry DUT
  logic           row_valid;
  logic           row_ready;
  logic [C*W-1:0] row_data;
  logic           pix_valid;
  logic           pix_ready;
  logic [W-1:0]   pix_data;
  logic [7:0]     pix_col;
  logic [7:0]     pix_row;
  logic           pix_eol, pix_sof, pix_eof, busy;

  // Small-frame DUT for frame wrap
  logic            s_row_valid;
  logic            s_row_ready;
  logic [SC*W-1:0] s_row_data;
  logic            s_pix_valid;
  logic            s_pix_ready;
  logic [W-1:0]    s_pix_data;
  logic [2:0]      s_pix_col;
  logic [1:0]      s_pix_row;
  logic            s_pix_eol, s_pix_sof, s_pix_eof, s_busy;

  gray_row_serializer #(
    .COLS  (C),
    .ROWS  (R),
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_col   (pix_col),
    .pix_row   (pix_row),
    .pix_eol   (pix_eol),
    .pix_sof   (pix_sof),
    .pix_eof   (pix_eof),
    .busy      (busy)
  );

  gray_row_serializer #(
    .COLS  (SC),
    .ROWS  (SR),
    .WIDTH (W)
  ) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_valid (s_row_valid),
    .row_ready (s_row_ready),
    .row_data  (s_row_data),
    .pix_valid (s_pix_valid),
    .pix_ready (s_pix_ready),
    .pix_data  (s_pix_data),
    .pix_col   (s_pix_col),
    .pix_row   (s_pix_row),
    .pix_eol   (s_pix_eol),
    .pix_sof   (s_pix_sof),
    .pix_eof   (s_pix_eof),
    .busy      (s_busy)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned exp_row = 0;

  logic [28:0] got, exp;
  logic [18:0] s_got, s_exp;

  function automatic logic [C*W-1:0] ramp_row(input logic [7:0] x);
    logic [C*W-1:0] v;
    for (int c = 0; c < C; c++) v[c*W +: W] = W'(c) ^ x;
    return v;
  endfunction

  function automatic logic [C*W-1:0] const_row(input logic [7:0] p);
    logic [C*W-1:0] v;
    for (int c = 0; c < C; c++) v[c*W +: W] = p;
    return v;
  endfunction

  function automatic logic [SC*W-1:0] small_row(input int r);
    logic [SC*W-1:0] v;
    for (int c = 0; c < SC; c++) v[c*W +: W] = W'(r * 16 + c);
    return v;
  endfunction

  task automatic test_reset();
    rst_n       = 1'b0;
    row_valid   = 1'b0;
    row_data    = '0;
    pix_ready   = 1'b0;
    s_row_valid = 1'b0;
    s_row_data  = '0;
    s_pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    got = {pix_valid, row_ready, pix_eol, pix_sof, pix_eof, pix_col, pix_row, pix_data};
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0};
    total++;
    if (got !== exp) begin bad++; $display("FAIL reset_state got=%h exp=%h", got, exp); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end

    // Reset in the middle of a row
    @(negedge clk);
    row_valid = 1'b1;
    row_data  = ramp_row(8'h00);
    pix_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    row_valid = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    total++;
    if ({pix_valid, pix_col, pix_data} !== {1'b1, 8'd100, 8'd100}) begin
      bad++;
      $display("FAIL mid_row_pos got=%h exp=%h", {pix_valid, pix_col, pix_data}, {1'b1, 8'd100, 8'd100});
    end
    #1 rst_n = 1'b0;
    #1;
    got = {pix_valid, row_ready, busy, pix_col, pix_row, pix_data};
    total++;
    if (got[25:0] !== {1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0}) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", got[25:0], {1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    got = {pix_valid, row_ready, busy, pix_col, pix_row, pix_data};
    total++;
    if (got[25:0] !== {1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0}) begin
      bad++;
      $display("FAIL after_reset got=%h exp=%h", got[25:0], {1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0});
    end
    exp_row = 0;
  endtask

  task automatic test_single_row();
    @(negedge clk);
    row_valid = 1'b1;
    row_data  = ramp_row(8'h00);
    pix_ready = 1'b1;
    #1;
    total++;
    if (row_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", row_ready); end
    @(posedge clk);
    for (int b = 0; b < C; b++) begin
      @(negedge clk);
      row_valid = 1'b0;
      #1;
      got = {pix_valid, row_ready, pix_eol, pix_sof, pix_eof, pix_col, pix_row, pix_data};
      exp = {1'b1, (b == C - 1), (b == C - 1), (exp_row == 0 && b == 0),
             (exp_row == R - 1 && b == C - 1), 8'(b), 8'(exp_row), 8'(b)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL single_row beat=%0d got=%h exp=%h", b, got, exp); end
    end
    @(negedge clk);
    #1;
    total++;
    if ({pix_valid, busy} !== 2'b00) begin bad++; $display("FAIL single_row_idle got=%b exp=00", {pix_valid, busy}); end
    exp_row = (exp_row + 1) % R;
  endtask

  task automatic test_back_to_back();
    int unsigned r;
    @(negedge clk);
    row_valid = 1'b1;
    row_data  = const_row(8'h11);
    pix_ready = 1'b1;
    @(posedge clk);
    for (int b = 0; b < 2 * C; b++) begin
      @(negedge clk);
      if (b == 0)   row_data  = const_row(8'h22);
      if (b == int'(C)) row_valid = 1'b0;
      #1;
      r   = (exp_row + (b >= int'(C) ? 1 : 0)) % R;
      got = {pix_valid, row_ready, pix_eol, pix_sof, pix_eof, pix_col, pix_row, pix_data};
      exp = {1'b1, (b % C == C - 1), (b % C == C - 1), (r == 0 && b % C == 0),
             (r == R - 1 && b % C == C - 1), 8'(b % C), 8'(r), (b < int'(C)) ? 8'h11 : 8'h22};
      total++;
      if (got !== exp) begin bad++; $display("FAIL back_to_back beat=%0d got=%h exp=%h", b, got, exp); end
    end
    @(negedge clk);
    #1;
    total++;
    if ({pix_valid, busy} !== 2'b00) begin bad++; $display("FAIL b2b_idle got=%b exp=00", {pix_valid, busy}); end
    exp_row = (exp_row + 2) % R;
  endtask

  task automatic test_backpressure();
    logic [7:0] lfsr;
    logic       r;
    int         idx;
    int         cyc;
    lfsr = 8'hA5;
    idx  = 0;
    cyc  = 0;
    @(negedge clk);
    row_valid = 1'b1;
    row_data  = ramp_row(8'h00);
    pix_ready = 1'b0;
    @(posedge clk);
    while (idx < int'(C) && cyc < 3000) begin
      @(negedge clk);
      row_valid = 1'b0;
      r    = lfsr[0];
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      pix_ready = r;
      #1;
      got = {pix_valid, row_ready, pix_eol, pix_sof, pix_eof, pix_col, pix_row, pix_data};
      exp = {1'b1, (r && idx == int'(C) - 1), (idx == int'(C) - 1), (exp_row == 0 && idx == 0),
             (exp_row == R - 1 && idx == int'(C) - 1), 8'(idx), 8'(exp_row), 8'(idx)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, got, exp); end
      if (r) idx++;
      cyc++;
    end
    total++;
    if (idx != int'(C)) begin bad++; $display("FAIL backpressure_timeout beats=%0d exp=%0d", idx, C); end
    pix_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({pix_valid, busy} !== 2'b00) begin bad++; $display("FAIL bp_idle got=%b exp=00", {pix_valid, busy}); end
    exp_row = (exp_row + 1) % R;
  endtask

  task automatic test_mutate();
    @(negedge clk);
    row_valid = 1'b1;
    row_data  = ramp_row(8'h5A);
    pix_ready = 1'b1;
    @(posedge clk);
    for (int b = 0; b < C; b++) begin
      @(negedge clk);
      if (b == 0) begin
        row_valid = 1'b0;
        row_data  = const_row(8'hFF);
      end
      #1;
      total++;
      if ({pix_col, pix_data} !== {8'(b), 8'(b) ^ 8'h5A}) begin
        bad++;
        $display("FAIL mutate beat=%0d got=%h exp=%h", b, {pix_col, pix_data}, {8'(b), 8'(b) ^ 8'h5A});
      end
    end
    @(negedge clk);
    exp_row = (exp_row + 1) % R;
  endtask

  task automatic test_frame_wrap();
    int r, c;
    @(negedge clk);
    s_row_valid = 1'b1;
    s_row_data  = small_row(0);
    s_pix_ready = 1'b1;
    @(posedge clk);
    for (int b = 0; b < 5 * int'(SC); b++) begin
      @(negedge clk);
      #1;
      r = b / int'(SC);
      c = b % int'(SC);
      s_got = {s_pix_valid, s_row_ready, s_pix_eol, s_pix_sof, s_pix_eof, s_pix_col, s_pix_row, s_pix_data};
      s_exp = {1'b1, (c == 7), (c == 7), (r % 4 == 0 && c == 0), (r % 4 == 3 && c == 7),
               3'(c), 2'(r % 4), 8'(r * 16 + c)};
      total++;
      if (s_got !== s_exp) begin bad++; $display("FAIL frame_wrap beat=%0d got=%h exp=%h", b, s_got, s_exp); end
      if (c == 7) begin
        if (r < 4) s_row_data  = small_row(r + 1);
        else       s_row_valid = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    total++;
    if ({s_pix_valid, s_busy} !== 2'b00) begin bad++; $display("FAIL frame_wrap_idle got=%b exp=00", {s_pix_valid, s_busy}); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_backpressure();
    test_mutate();
    test_frame_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_gray_row_serializer
